color_sensor_emulator: RTL

Synthesizable stand-in for the TCS3200-style colour sensor that the line follower's colour-detection block drives and measures. It decodes the filter select (s2/s3) and frequency-scaling (s0/s1) pins and generates a square wave whose frequency is set per filter from programmable half-period registers. It sits on the sensor side of the interface, either in a loop-back test build or in the verification bench. With it, the colour-detection block can be exercised end to end without optics.

---
 rtl/color_sensor_emulator_if.sv | 31 +++
 rtl/color_sensor_emulator.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/color_sensor_emulator_if.sv
// Sensor-side pin bundle of the TCS3200-style colour sensor emulator.
// master = colour-detection block (drives select pins), slave = emulator.
interface color_sensor_emulator_if #(
   parameter int unsigned HP_W = 16
);
   logic            s0;
   logic            s1;
   logic            s2;
   logic            s3;
   logic            oe_n;
   logic            load;
   logic [HP_W-1:0] hp_red;
   logic [HP_W-1:0] hp_green;
   logic [HP_W-1:0] hp_blue;
   logic [HP_W-1:0] hp_clear;
   logic            ip_signal;
   logic [1:0]      channel;
   logic            running;

   modport master (
      output s0, s1, s2, s3, oe_n, load,
      output hp_red, hp_green, hp_blue, hp_clear,
      input  ip_signal, channel, running
   );

   modport slave (
      input  s0, s1, s2, s3, oe_n, load,
      input  hp_red, hp_green, hp_blue, hp_clear,
      output ip_signal, channel, running
   );
endinterface

// File: rtl/color_sensor_emulator.sv
// TCS3200-style colour sensor emulator: square wave whose half-period is
// selected per filter from programmable registers, scaled by s0/s1.
module color_sensor_emulator #(
   parameter int unsigned HP_W          = 16,
   parameter int unsigned SETTLE_CYCLES = 16
) (
   input logic                    clk,
   input logic                    rst_n,
   color_sensor_emulator_if.slave bus
);
   localparam int unsigned     CW          = HP_W + 6;
   localparam logic [CW-1:0]   ONE         = CW'(1);
   localparam logic [CW-1:0]   SETTLE_LAST = CW'(SETTLE_CYCLES - 1);

   typedef enum logic [1:0] {PD, SETTLE, RUN} state_t;

   state_t          state, state_nx;
   logic [3:0]      sel_q;
   logic [1:0]      scale_sel, filt_sel;
   logic [HP_W-1:0] hp_r, hp_g, hp_b, hp_c, hp_sel;
   logic [5:0]      scale;
   logic [CW-1:0]   h_new;
   logic [CW-1:0]   cnt, cnt_nx;
   logic [CW-1:0]   h_q, h_nx;
   logic            phase, phase_nx;
   logic [1:0]      chan_q, chan_nx;

   assign scale_sel = sel_q[3:2];
   assign filt_sel  = sel_q[1:0];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sel_q <= '0;
         hp_r  <= '0;
         hp_g  <= '0;
         hp_b  <= '0;
         hp_c  <= '0;
      end else begin
         sel_q <= {bus.s0, bus.s1, bus.s2, bus.s3};
         if (bus.load) begin
            hp_r <= bus.hp_red;
            hp_g <= bus.hp_green;
            hp_b <= bus.hp_blue;
            hp_c <= bus.hp_clear;
         end
      end
   end

   always_comb begin
      hp_sel = hp_r;
      case (filt_sel)
         2'b00:   hp_sel = hp_r;
         2'b01:   hp_sel = hp_b;
         2'b10:   hp_sel = hp_c;
         default: hp_sel = hp_g;
      endcase
      scale = 6'd0;
      case (scale_sel)
         2'b01:   scale = 6'd50;
         2'b10:   scale = 6'd5;
         2'b11:   scale = 6'd1;
         default: scale = 6'd0;
      endcase
      h_new = {6'd0, hp_sel} * {{HP_W{1'b0}}, scale};
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= SETTLE;
         cnt    <= '0;
         h_q    <= '0;
         phase  <= 1'b1;
         chan_q <= 2'b00;
      end else begin
         state  <= state_nx;
         cnt    <= cnt_nx;
         h_q    <= h_nx;
         phase  <= phase_nx;
         chan_q <= chan_nx;
      end
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      h_nx     = h_q;
      phase_nx = phase;
      chan_nx  = chan_q;
      if (scale_sel == 2'b00) begin
         state_nx = PD;
         cnt_nx   = '0;
         phase_nx = 1'b1;
      end else begin
         case (state)
            PD: begin
               state_nx = SETTLE;
               cnt_nx   = '0;
               phase_nx = 1'b1;
            end
            SETTLE: begin
               chan_nx = filt_sel;
               if (cnt == SETTLE_LAST) begin
                  state_nx = RUN;
                  cnt_nx   = '0;
                  phase_nx = 1'b1;
                  h_nx     = h_new;
               end else begin
                  cnt_nx = cnt + ONE;
               end
            end
            RUN: begin
               // Filter change outranks the half-period boundary; a zero H
               // re-samples the registers every cycle so a load restarts at high.
               if (filt_sel != chan_q) begin
                  state_nx = SETTLE;
                  cnt_nx   = '0;
                  phase_nx = 1'b1;
               end else if (h_q == '0) begin
                  cnt_nx   = '0;
                  phase_nx = 1'b1;
                  h_nx     = h_new;
               end else if (cnt == h_q - ONE) begin
                  cnt_nx   = '0;
                  phase_nx = ~phase;
                  h_nx     = h_new;
               end else begin
                  cnt_nx = cnt + ONE;
               end
            end
            default: begin
               state_nx = SETTLE;
               cnt_nx   = '0;
               phase_nx = 1'b1;
            end
         endcase
      end
   end

   assign bus.running   = (state == RUN);
   assign bus.channel   = chan_q;
   assign bus.ip_signal = (state == RUN) && phase && !bus.oe_n && (h_q != '0);
endmodule
